// File: rtl/pattern_loader_pkg.sv
// Shared types and defaults for the pattern loader: board geometry, cell
// position type, loader state enum and the toroidal wrap helper.
package pattern_loader_pkg;

   localparam int BOARD_W_DEF = 64;
   localparam int BOARD_H_DEF = 48;
   localparam int PAT_DIM_DEF = 8;
   localparam int POS_W = $clog2((BOARD_W_DEF > BOARD_H_DEF) ? BOARD_W_DEF : BOARD_H_DEF);

   typedef logic [POS_W-1:0] pos_t;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FETCH,
      STAMP,
      DONE
   } pl_state_t;

   // One compare-and-subtract is enough: both operands are already below the bound.
   function automatic pos_t wrap_pos(input logic [POS_W:0] sum, input logic [POS_W:0] bound);
      logic [POS_W:0] r;
      r = (sum >= bound) ? (sum - bound) : sum;
      return r[POS_W-1:0];
   endfunction

endpackage

// File: rtl/pattern_loader_rom.sv
// Pattern ROM: 8 patterns of PAT_DIM rows, bit c of a row is column c.
// Synchronous read, data valid the cycle after rd_en.
module pattern_rom
   import pattern_loader_pkg::*;
#(
   parameter int PAT_DIM = PAT_DIM_DEF,
   parameter int ROW_W   = 3
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rd_en,
   input  logic [2:0]         sel,
   input  logic [ROW_W-1:0]   row,
   output logic [PAT_DIM-1:0] bits
);

   logic [7:0] row_data;

   // 0 empty, 1 glider, 2 blinker, 3 block, 4 LWSS, 5 R-pentomino, 6 frame, 7 checkerboard
   always_comb begin
      row_data = 8'h00;
      case (sel)
         3'd1: case (int'(row))
                  0: row_data = 8'h02;
                  1: row_data = 8'h04;
                  2: row_data = 8'h07;
                  default: row_data = 8'h00;
               endcase
         3'd2: row_data = (int'(row) == 0) ? 8'h07 : 8'h00;
         3'd3: row_data = (int'(row) <= 1) ? 8'h03 : 8'h00;
         3'd4: case (int'(row))
                  0: row_data = 8'h12;
                  1: row_data = 8'h01;
                  2: row_data = 8'h11;
                  3: row_data = 8'h0F;
                  default: row_data = 8'h00;
               endcase
         3'd5: case (int'(row))
                  0: row_data = 8'h06;
                  1: row_data = 8'h03;
                  2: row_data = 8'h02;
                  default: row_data = 8'h00;
               endcase
         3'd6: row_data = (int'(row) == 0 || int'(row) == 7) ? 8'hFF : 8'h81;
         3'd7: row_data = row[0] ? 8'hAA : 8'h55;
         default: row_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         bits <= '0;
      end else if (rd_en) begin
         bits <= PAT_DIM'(row_data);
      end
   end

endmodule

// File: rtl/pattern_loader.sv
// Pattern loader: optionally clears the life board, then stamps a ROM pattern
// at a toroidally wrapped origin through a ready/valid cell-write port.
//
// state | meaning
// IDLE  | waiting for load_in; latches pattern select and origin
// CLEAR | writing 0 to every cell in raster order
// FETCH | one-cycle ROM read of the current pattern row
// STAMP | writing the PAT_DIM cells of the current row
// DONE  | one-cycle completion pulse
module pattern_loader
   import pattern_loader_pkg::*;
#(
   parameter int BOARD_W = BOARD_W_DEF,
   parameter int BOARD_H = BOARD_H_DEF,
   parameter int PAT_DIM = PAT_DIM_DEF
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       load_in,
   input  logic       clear_in,
   input  logic [2:0] pattern_sel_in,
   input  pos_t       origin_x_in,
   input  pos_t       origin_y_in,
   input  logic       wr_ready_in,
   output logic       wr_en_out,
   output pos_t       wr_x_out,
   output pos_t       wr_y_out,
   output logic       alive_out,
   output logic       busy_out,
   output logic       done_out
);

   localparam int ROW_W = (PAT_DIM > 1) ? $clog2(PAT_DIM) : 1;
   localparam logic [POS_W:0]   W_LIM    = (POS_W+1)'(BOARD_W);
   localparam logic [POS_W:0]   H_LIM    = (POS_W+1)'(BOARD_H);
   localparam pos_t             X_LAST   = POS_W'(BOARD_W - 1);
   localparam pos_t             Y_LAST   = POS_W'(BOARD_H - 1);
   localparam logic [ROW_W-1:0] IDX_LAST = ROW_W'(PAT_DIM - 1);

   pl_state_t          state, state_nx;
   logic [2:0]         sel_q;
   pos_t               ox_q, oy_q, cx, cy;
   logic [ROW_W-1:0]   row, col;
   logic [PAT_DIM-1:0] rom_bits;
   logic               rom_rd, wr_active, xfer, clear_last, col_last;

   assign wr_active  = (state == CLEAR) || (state == STAMP);
   assign xfer       = wr_active & wr_ready_in;
   assign clear_last = (cx == X_LAST) && (cy == Y_LAST);
   assign col_last   = (col == IDX_LAST);

   pattern_rom #(.PAT_DIM(PAT_DIM), .ROW_W(ROW_W)) u_rom (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rd_en  (rom_rd),
      .sel    (sel_q),
      .row    (row),
      .bits   (rom_bits)
   );

   always_comb begin
      state_nx  = state;
      rom_rd    = 1'b0;
      wr_en_out = wr_active;
      wr_x_out  = '0;
      wr_y_out  = '0;
      alive_out = 1'b0;
      busy_out  = 1'b1;
      done_out  = 1'b0;
      case (state)
         IDLE: begin
            busy_out = 1'b0;
            if (load_in) state_nx = clear_in ? CLEAR : FETCH;
         end
         CLEAR: begin
            wr_x_out = cx;
            wr_y_out = cy;
            if (xfer && clear_last) state_nx = FETCH;
         end
         FETCH: begin
            rom_rd   = 1'b1;
            state_nx = STAMP;
         end
         STAMP: begin
            wr_x_out  = wrap_pos({1'b0, ox_q} + (POS_W+1)'(col), W_LIM);
            wr_y_out  = wrap_pos({1'b0, oy_q} + (POS_W+1)'(row), H_LIM);
            alive_out = rom_bits[col];
            if (xfer && col_last) state_nx = (row == IDX_LAST) ? DONE : FETCH;
         end
         DONE: begin
            done_out = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= IDLE;
         sel_q <= '0;
         ox_q  <= '0;
         oy_q  <= '0;
         cx    <= '0;
         cy    <= '0;
         row   <= '0;
         col   <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (load_in) begin
               sel_q <= pattern_sel_in;
               ox_q  <= wrap_pos({1'b0, origin_x_in}, W_LIM);
               oy_q  <= wrap_pos({1'b0, origin_y_in}, H_LIM);
               cx    <= '0;
               cy    <= '0;
               row   <= '0;
               col   <= '0;
            end
            CLEAR: if (xfer) begin
               if (cx == X_LAST) begin
                  cx <= '0;
                  cy <= (cy == Y_LAST) ? '0 : cy + pos_t'(1);
               end else begin
                  cx <= cx + pos_t'(1);
               end
            end
            STAMP: if (xfer) begin
               if (col_last) begin
                  col <= '0;
                  row <= row + ROW_W'(1);
               end else begin
                  col <= col + ROW_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_loader.sv
// Self-checking bench for pattern_loader: every transfer is captured and
// compared against a list built from the pattern shapes with plain modulo arithmetic.
module tb_pattern_loader;
   import pattern_loader_pkg::*;

   localparam int W = 64, H = 48, P = 8, BUDGET = 12000;

   typedef struct packed { pos_t x; pos_t y; logic a; } cell_t;

   logic       clk_in = 1'b0, rst_in = 1'b0, load_in = 1'b0, clear_in = 1'b0, wr_ready_in = 1'b1;
   logic [2:0] pattern_sel_in = '0;
   pos_t       origin_x_in = '0, origin_y_in = '0;
   logic       wr_en_out, alive_out, busy_out, done_out;
   pos_t       wr_x_out, wr_y_out;

   int    checks = 0, errors = 0;
   cell_t got[$], exp_q[$], ref_q[$];
   logic  pend = 1'b0;
   cell_t held;

   always #5 clk_in = ~clk_in;

   pattern_loader dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .load_in        (load_in),
      .clear_in       (clear_in),
      .pattern_sel_in (pattern_sel_in),
      .origin_x_in    (origin_x_in),
      .origin_y_in    (origin_y_in),
      .wr_ready_in    (wr_ready_in),
      .wr_en_out      (wr_en_out),
      .wr_x_out       (wr_x_out),
      .wr_y_out       (wr_y_out),
      .alive_out      (alive_out),
      .busy_out       (busy_out),
      .done_out       (done_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Live cells of each named pattern, row r / column c from its top-left corner.
   function automatic bit pat_live(input int s, input int r, input int c);
      case (s)
         1: return (r == 0 && c == 1) || (r == 1 && c == 2) || (r == 2 && c <= 2);
         2: return r == 0 && c <= 2;
         3: return r <= 1 && c <= 1;
         4: return (r == 0 && (c == 1 || c == 4)) || (r == 1 && c == 0) ||
                   (r == 2 && (c == 0 || c == 4)) || (r == 3 && c <= 3);
         default: return 1'b0;
      endcase
   endfunction

   task automatic build_exp(input bit cl, input int s, input int x0, input int y0);
      exp_q.delete();
      if (cl)
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
               exp_q.push_back(cell_t'{pos_t'(x), pos_t'(y), 1'b0});
      for (int r = 0; r < P; r++)
         for (int c = 0; c < P; c++)
            exp_q.push_back(cell_t'{pos_t'((x0 + c) % W), pos_t'((y0 + r) % H), pat_live(s, r, c)});
   endtask

   // Transfer capture and hold-during-stall check; ready only changes just after posedge.
   always @(negedge clk_in) begin
      if (pend)
         chk("stall_hold", {wr_en_out, wr_x_out, wr_y_out, alive_out}, {1'b1, held.x, held.y, held.a});
      if (rst_in === 1'b1 && wr_en_out === 1'b1 && wr_ready_in === 1'b1)
         got.push_back(cell_t'{wr_x_out, wr_y_out, alive_out});
      pend = (rst_in === 1'b1 && wr_en_out === 1'b1 && wr_ready_in === 1'b0);
      held = cell_t'{wr_x_out, wr_y_out, alive_out};
   end

   task automatic run_load(input bit cl, input int s, input int x0, input int y0,
                           input int stall_pct, input int inject_at, input bit armed,
                           output int cycles);
      bit seen = 1'b0;
      got.delete();
      if (!armed) begin
         @(posedge clk_in);
         #1;
      end
      load_in = 1'b1; clear_in = cl; pattern_sel_in = 3'(s);
      origin_x_in = pos_t'(x0); origin_y_in = pos_t'(y0); wr_ready_in = 1'b1;
      @(posedge clk_in);
      #1;
      load_in = 1'b0; clear_in = ~cl; pattern_sel_in = 3'(s + 3);
      origin_x_in = pos_t'($urandom); origin_y_in = pos_t'($urandom);
      cycles = 1;
      while (!seen && cycles < BUDGET) begin
         wr_ready_in = (stall_pct == 0) ? 1'b1 : 1'($urandom_range(0, 99) >= stall_pct);
         if (cycles == inject_at) begin
            load_in = 1'b1; clear_in = 1'b1; pattern_sel_in = 3'(s + 1);
         end else begin
            load_in = 1'b0; clear_in = 1'b0;
         end
         @(negedge clk_in);
         if (cycles == 1) chk("lat_first", wr_en_out, cl);
         if (cycles == 2) chk("lat_second", wr_en_out, 1);
         if (done_out === 1'b1) seen = 1'b1;
         else chk("busy", busy_out, 1);
         if (!seen) begin
            @(posedge clk_in);
            #1;
            cycles++;
         end
      end
      wr_ready_in = 1'b1; load_in = 1'b0; clear_in = 1'b0;
      chk("timeout", seen, 1);
      if (seen) begin
         @(negedge clk_in);
         chk("done_pulse", {done_out, busy_out}, 0);
      end
   endtask

   task automatic compare_list(input string tag);
      chk({tag, "_len"}, got.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i >= got.size()) break;
         chk({tag, "_cell"}, got[i], exp_q[i]);
         if (got[i] !== exp_q[i]) break;
      end
   endtask

   initial begin
      int cyc, live, diffs, s, x0, y0, stall;
      bit cl;

      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_outputs", {wr_en_out, busy_out, done_out, alive_out, wr_x_out, wr_y_out}, 0);

      // Glider, load offered on the first edge after reset release.
      @(negedge clk_in);
      rst_in = 1'b1;
      build_exp(0, 1, 10, 10);
      run_load(0, 1, 10, 10, 0, -1, 1, cyc);
      chk("glider_cycles", cyc, P * (P + 1) + 1);
      compare_list("glider");
      live = 0;
      foreach (got[i]) if (got[i].a) live++;
      chk("glider_live", live, 5);
      ref_q = got;

      // Block near the far corner: stamp wraps in both axes.
      build_exp(0, 3, 60, 45);
      run_load(0, 3, 60, 45, 0, -1, 0, cyc);
      compare_list("block");
      chk("blk_00", got[0],  cell_t'{6'd60, 6'd45, 1'b1});
      chk("blk_01", got[1],  cell_t'{6'd61, 6'd45, 1'b1});
      chk("blk_10", got[8],  cell_t'{6'd60, 6'd46, 1'b1});
      chk("blk_11", got[9],  cell_t'{6'd61, 6'd46, 1'b1});
      chk("blk_77", got[63], cell_t'{6'd3,  6'd4,  1'b0});

      // Full clear then glider.
      build_exp(1, 1, 10, 10);
      run_load(1, 1, 10, 10, 0, -1, 0, cyc);
      compare_list("clear");
      chk("clear_cycles", cyc, 1 + W * H + P * (P + 1));

      // Same glider with 30% ready stalls must produce the identical write stream.
      build_exp(0, 1, 10, 10);
      run_load(0, 1, 10, 10, 30, -1, 0, cyc);
      compare_list("stall");
      chk("stall_ref_len", got.size(), ref_q.size());
      diffs = 0;
      foreach (ref_q[i]) if (i >= got.size() || got[i] !== ref_q[i]) diffs++;
      chk("stall_ref_diffs", diffs, 0);

      // Second load mid-STAMP is ignored; origin y beyond the board is reduced.
      build_exp(0, 4, 63, 50);
      run_load(0, 4, 63, 50, 0, 5, 0, cyc);
      compare_list("inject");
      chk("inject_cycles", cyc, P * (P + 1) + 1);

      // Reset while clearing cell 500.
      got.delete();
      @(posedge clk_in);
      #1;
      load_in = 1'b1; clear_in = 1'b1; pattern_sel_in = 3'd2;
      origin_x_in = pos_t'(7); origin_y_in = pos_t'(7);
      @(posedge clk_in);
      #1;
      load_in = 1'b0; clear_in = 1'b0;
      for (int i = 0; i < 1000 && got.size() < 500; i++) begin
         @(posedge clk_in);
         #1;
      end
      chk("rst_cell_cnt", got.size(), 500);
      chk("rst_cell_addr", {wr_en_out, wr_x_out, wr_y_out}, {1'b1, 6'd52, 6'd7});
      rst_in = 1'b0;
      #1;
      chk("rst_mid_outputs", {wr_en_out, busy_out, done_out, alive_out, wr_x_out, wr_y_out}, 0);
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      chk("rst_hold_outputs", {wr_en_out, busy_out, done_out, alive_out, wr_x_out, wr_y_out}, 0);
      rst_in = 1'b1;
      build_exp(1, 2, 5, 40);
      run_load(1, 2, 5, 40, 0, -1, 1, cyc);
      compare_list("post_rst");

      // Randomised loads.
      for (int n = 0; n < 6; n++) begin
         cl    = ($urandom_range(0, 3) == 0);
         s     = $urandom_range(0, 4);
         x0    = $urandom_range(0, 63);
         y0    = $urandom_range(0, 63);
         stall = ($urandom_range(0, 1) == 1) ? 25 : 0;
         build_exp(cl, s, x0, y0);
         run_load(cl, s, x0, y0, stall, -1, 0, cyc);
         compare_list("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
